// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared widths, operation/state encodings and sign helpers
// for the RV32M multi-cycle divide sequencer.
package div_seq_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int RDATA_WIDTH  = 32;
    localparam int RADDR_WIDTH  = 5;
    localparam int DIV_ITER_NUM = 32;
    localparam int CNT_WIDTH    = 5;

    // Counter value of the last restoring step (DIV_ITER_NUM - 1)
    localparam logic [CNT_WIDTH-1:0] DIV_CNT_LAST = 5'd31;

    // funct3[1:0] encodings of the divide family
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_STATE_IDLE = 2'b00,
        DIV_STATE_CALC = 2'b01,
        DIV_STATE_DONE = 2'b10
    } div_state_e;

    // Magnitude of a two's complement operand. The negation is done as an
    // unsigned subtraction, so -2^31 maps exactly onto 2^31.
    function automatic logic [DATA_WIDTH-1:0] magnitude(
        input logic [DATA_WIDTH-1:0] value,
        input logic                  neg
    );
        logic [DATA_WIDTH-1:0] mag;
        if (neg) begin
            mag = 32'd0 - value;
        end else begin
            mag = value;
        end
        return mag;
    endfunction

    // Re-applies a sign to an unsigned magnitude
    function automatic logic [DATA_WIDTH-1:0] apply_sign(
        input logic [DATA_WIDTH-1:0] value,
        input logic                  neg
    );
        logic [DATA_WIDTH-1:0] res;
        if (neg) begin
            res = 32'd0 - value;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
// Shifts the next dividend bit into the partial remainder and keeps the
// trial subtraction only when it does not go negative.
module div_step
    import div_seq_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic                  dvd_msb,
    input  logic [DATA_WIDTH-1:0] dvs,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic                  q_bit
);

    logic [DATA_WIDTH:0] shifted_s;
    logic [DATA_WIDTH:0] trial_s;

    // Trial subtraction and restore decision
    always_comb begin
        shifted_s = {rem, dvd_msb};
        trial_s   = shifted_s - {1'b0, dvs};
        if (!trial_s[DATA_WIDTH]) begin
            rem_next = trial_s[DATA_WIDTH-1:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted_s[DATA_WIDTH-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle sequencer for DIV/DIVU/REM/REMU.
// Runs 32 restoring steps on operand magnitudes, then fixes signs and
// special cases in DONE and presents a one-cycle write-back pulse.
// Optional build macro: DIV_FAST_SPECIAL_EN -- divide-by-zero and signed
// overflow skip the iterations and go straight from IDLE to DONE.
module div_seq
    import div_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [1:0]             op_i,
    input  logic [DATA_WIDTH-1:0]  dividend_i,
    input  logic [DATA_WIDTH-1:0]  divisor_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   hold_o,
    output logic                   ready_o,
    output logic [RDATA_WIDTH-1:0] result_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o
);

    div_state_e             state_r;
    div_state_e             state_next_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic                   is_rem_r;
    logic [RADDR_WIDTH-1:0] rd_r;
    logic [DATA_WIDTH-1:0]  dvd_r;       // dividend shifts out, quotient shifts in
    logic [DATA_WIDTH-1:0]  dvs_r;
    logic [DATA_WIDTH-1:0]  rem_r;
    logic [DATA_WIDTH-1:0]  dvd_raw_r;   // original rs1, the divide-by-zero remainder
    logic                   sign_dvd_r;
    logic                   sign_dvs_r;
    logic                   div_zero_r;
    logic                   ovf_r;

    logic                   ready_r;
    logic [RDATA_WIDTH-1:0] result_r;
    logic [RADDR_WIDTH-1:0] waddr_r;

    logic                   accept_s;
    logic                   op_signed_s;
    logic                   div_zero_s;
    logic                   ovf_s;
    logic                   special_s;
    logic [DATA_WIDTH-1:0]  step_rem_s;
    logic                   step_q_s;
    logic [DATA_WIDTH-1:0]  quot_fix_s;
    logic [DATA_WIDTH-1:0]  rem_fix_s;
    logic [RDATA_WIDTH-1:0] fix_result_s;
    logic                   hold_s;
    logic                   busy_s;

    div_step u_div_step (
        .rem      (rem_r),
        .dvd_msb  (dvd_r[DATA_WIDTH-1]),
        .dvs      (dvs_r),
        .rem_next (step_rem_s),
        .q_bit    (step_q_s)
    );

    // Request decode: acceptance and special-case detection on raw operands
    always_comb begin
        accept_s    = (state_r == DIV_STATE_IDLE) && start_i && !flush_i;
        op_signed_s = !op_i[0];
        div_zero_s  = (divisor_i == 32'd0);
        ovf_s       = op_signed_s && (dividend_i == 32'h8000_0000)
                      && (divisor_i == 32'hFFFF_FFFF);
        special_s   = div_zero_s || ovf_s;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DIV_STATE_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; flush always returns to IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIV_STATE_IDLE: begin
                if (accept_s) begin
`ifdef DIV_FAST_SPECIAL_EN
                    if (special_s) begin
                        state_next_s = DIV_STATE_DONE;
                    end else begin
                        state_next_s = DIV_STATE_CALC;
                    end
`else
                    state_next_s = DIV_STATE_CALC;
`endif
                end else begin
                    state_next_s = DIV_STATE_IDLE;
                end
            end
            DIV_STATE_CALC: begin
                if (flush_i) begin
                    state_next_s = DIV_STATE_IDLE;
                end else if (cnt_r == DIV_CNT_LAST) begin
                    state_next_s = DIV_STATE_DONE;
                end else begin
                    state_next_s = DIV_STATE_CALC;
                end
            end
            DIV_STATE_DONE: begin
                state_next_s = DIV_STATE_IDLE;
            end
            default: begin
                state_next_s = DIV_STATE_IDLE;
            end
        endcase
    end

    // FSM outputs: pipeline hold (dropped in DONE so write-back can advance)
    always_comb begin
        hold_s = 1'b0;
        busy_s = 1'b0;
        case (state_r)
            DIV_STATE_IDLE: begin
                hold_s = start_i && !flush_i && !rst;
                busy_s = 1'b0;
            end
            DIV_STATE_CALC: begin
                hold_s = !rst;
                busy_s = 1'b1;
            end
            DIV_STATE_DONE: begin
                hold_s = 1'b0;
                busy_s = 1'b1;
            end
            default: begin
                hold_s = 1'b0;
                busy_s = 1'b0;
            end
        endcase
    end

    // Operand capture on accept, one restoring step per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= 5'd0;
            is_rem_r   <= 1'b0;
            rd_r       <= 5'd0;
            dvd_r      <= 32'd0;
            dvs_r      <= 32'd0;
            rem_r      <= 32'd0;
            dvd_raw_r  <= 32'd0;
            sign_dvd_r <= 1'b0;
            sign_dvs_r <= 1'b0;
            div_zero_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            case (state_r)
                DIV_STATE_IDLE: begin
                    if (accept_s) begin
                        cnt_r      <= 5'd0;
                        is_rem_r   <= op_i[1];
                        rd_r       <= reg_waddr_i;
                        sign_dvd_r <= op_signed_s && dividend_i[DATA_WIDTH-1];
                        sign_dvs_r <= op_signed_s && divisor_i[DATA_WIDTH-1];
                        dvd_r      <= magnitude(dividend_i,
                                                op_signed_s && dividend_i[DATA_WIDTH-1]);
                        dvs_r      <= magnitude(divisor_i,
                                                op_signed_s && divisor_i[DATA_WIDTH-1]);
                        rem_r      <= 32'd0;
                        dvd_raw_r  <= dividend_i;
                        div_zero_r <= div_zero_s;
                        ovf_r      <= ovf_s;
                    end
                end
                DIV_STATE_CALC: begin
                    rem_r <= step_rem_s;
                    dvd_r <= {dvd_r[DATA_WIDTH-2:0], step_q_s};
                    cnt_r <= cnt_r + 5'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Sign fix-up and special-case override of the raw quotient/remainder
    always_comb begin
        if (div_zero_r) begin
            quot_fix_s = 32'hFFFF_FFFF;
            rem_fix_s  = dvd_raw_r;
        end else if (ovf_r) begin
            quot_fix_s = 32'h8000_0000;
            rem_fix_s  = 32'd0;
        end else begin
            quot_fix_s = apply_sign(dvd_r, sign_dvd_r ^ sign_dvs_r);
            rem_fix_s  = apply_sign(rem_r, sign_dvd_r);
        end
        if (is_rem_r) begin
            fix_result_s = rem_fix_s;
        end else begin
            fix_result_s = quot_fix_s;
        end
    end

    // Registered write-back outputs; a flush in DONE cancels the pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r  <= 1'b0;
            result_r <= 32'd0;
            waddr_r  <= 5'd0;
        end else if ((state_r == DIV_STATE_DONE) && !flush_i) begin
            ready_r  <= 1'b1;
            result_r <= fix_result_s;
            waddr_r  <= rd_r;
        end else begin
            ready_r  <= 1'b0;
        end
    end

    assign busy_o      = busy_s;
    assign hold_o      = hold_s;
    assign ready_o     = ready_r;
    assign reg_we_o    = ready_r;
    assign result_o    = result_r;
    assign reg_waddr_o = waddr_r;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq. Expected results
// come from plain integer arithmetic and a timing model of when hold, busy
// and the write-back pulse must appear.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        busy_o;
    logic        hold_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;

    div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .hold_o      (hold_o),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour of the four divide instructions
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (op)
            2'b00: if (b == 0) r = 32'hFFFF_FFFF;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                   else r = sa / sb;
            2'b01: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
            2'b10: if (b == 0) r = a;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                   else r = sa % sb;
            default: if (b == 0) r = a; else r = a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Timing model: windows for hold/busy, queue of expected write-backs
    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;
    exp_t exp_q[$];

    bit          m_valid = 1'b0;
    int          m_hold_lo = 0, m_hold_hi = -1;
    int          m_busy_lo = 0, m_busy_hi = -1;
    int          m_last_ready = 0;
    int          m_zero_cyc = -1;
    logic [31:0] m_last_res = 32'd0;
    bit          chk_en = 1'b0;

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        bit eh, eb, er;
        if (chk_en) begin
            eh = m_valid && cyc >= m_hold_lo && cyc <= m_hold_hi;
            eb = m_valid && cyc >= m_busy_lo && cyc <= m_busy_hi;
            if (exp_q.size() > 0) er = (exp_q[0].cyc == cyc);
            else er = 1'b0;
            if (cyc == m_zero_cyc) m_last_res = 32'd0;
            chk("hold_o", {31'd0, hold_o}, {31'd0, eh});
            chk("busy_o", {31'd0, busy_o}, {31'd0, eb});
            chk("ready_o", {31'd0, ready_o}, {31'd0, er});
            chk("reg_we_o", {31'd0, reg_we_o}, {31'd0, er});
            if (er) begin
                chk("result_o", result_o, exp_q[0].res);
                chk("reg_waddr_o", {27'd0, reg_waddr_o}, {27'd0, exp_q[0].rd});
                m_last_res = exp_q[0].res;
                void'(exp_q.pop_front());
            end else begin
                chk("result_hold", result_o, m_last_res);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a request for one cycle and record what it must produce
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int c;
        bit sp;
        exp_t e;
        sp = 1'b0;
`ifdef DIV_FAST_SPECIAL_EN
        sp = is_special(op, a, b);
`endif
        c = cyc;
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
        m_valid   = 1'b1;
        m_hold_lo = c;
        m_hold_hi = sp ? c : c + 32;
        m_busy_lo = c + 1;
        m_busy_hi = sp ? c + 1 : c + 33;
        e.cyc = sp ? c + 2 : c + 34;
        e.res = model(op, a, b);
        e.rd  = rd;
        m_last_ready = e.cyc;
        exp_q.push_back(e);
        step(1);
        start_i = 1'b0; dividend_i = ~a; divisor_i = 32'h0000_0003; reg_waddr_i = ~rd;
    endtask

    task automatic wait_done();
        while (cyc <= m_last_ready) step(1);
    endtask

    // Cancel the in-flight op with reset (is_rst=1) or flush at the current cycle
    task automatic cancel(input bit is_rst);
        void'(exp_q.pop_back());
        m_busy_hi = cyc;
        if (is_rst) begin
            m_hold_hi  = cyc - 1;
            m_zero_cyc = cyc + 1;
            rst = 1'b1;
        end else begin
            m_hold_hi = cyc;
            flush_i = 1'b1;
        end
        step(1);
        rst = 1'b0;
        flush_i = 1'b0;
    endtask

    initial begin
        int c0;
        rst = 1'b1; start_i = 1'b1; flush_i = 1'b0; op_i = 2'b01;
        dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd1;

        // model pins
        chk("pin_divu_100_7", model(2'b01, 32'd100, 32'd7), 32'd14);
        chk("pin_div_m7_2", model(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem_m7_2", model(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_remu_f9_2", model(2'b11, 32'hFFFF_FFF9, 32'd2), 32'd1);
        chk("pin_div_5_0", model(2'b00, 32'd5, 32'd0), 32'hFFFF_FFFF);
        chk("pin_remu_5_0", model(2'b11, 32'd5, 32'd0), 32'd5);
        chk("pin_div_ovf", model(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("pin_rem_ovf", model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
        chk("pin_special", {31'd0, is_special(2'b01, 32'h8000_0000, 32'hFFFF_FFFF)}, 32'd0);

        // reset state, with start held high to show it is not accepted
        #1;
        step(3);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_hold", {31'd0, hold_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_we", {31'd0, reg_we_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
        rst = 1'b0; start_i = 1'b0;
        step(1);
        chk_en = 1'b1;

        // basic ops; REM issued back-to-back in the ready cycle of DIV
        issue(2'b01, 32'd100, 32'd7, 5'd5);
        wait_done();
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6);
        while (cyc < m_last_ready) step(1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd7);
        wait_done();
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd8);
        wait_done();
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd11);
        wait_done();
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd12);
        wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd13);
        wait_done();

        // divide by zero and signed overflow
        issue(2'b00, 32'd5, 32'd0, 5'd14);
        wait_done();
        issue(2'b11, 32'd5, 32'd0, 5'd15);
        wait_done();
        issue(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd16);
        wait_done();
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
        wait_done();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18);
        wait_done();

        // start coinciding with flush in IDLE is dropped
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01;
        dividend_i = 32'd50; divisor_i = 32'd5; reg_waddr_i = 5'd19;
        step(1);
        start_i = 1'b0; flush_i = 1'b0;
        step(2);

        // flush in CALC iteration 10, then an immediate new start
        issue(2'b01, 32'hFFFF_FFFF, 32'd3, 5'd9);
        c0 = cyc - 1;
        while (cyc < c0 + 11) step(1);
        cancel(1'b0);
        issue(2'b01, 32'd1000, 32'd10, 5'd10);
        // start pulsed mid-CALC is ignored
        step(8);
        start_i = 1'b1; op_i = 2'b00; dividend_i = 32'd77; divisor_i = 32'd7;
        reg_waddr_i = 5'd30;
        step(1);
        start_i = 1'b0;
        wait_done();

        // reset mid-CALC, then a fresh op right after reset
        issue(2'b00, 32'd12345, 32'hFFFF_FFEF, 5'd20);
        c0 = cyc - 1;
        while (cyc < c0 + 16) step(1);
        cancel(1'b1);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
        chk("mid_rst_we", {31'd0, reg_we_o}, 32'd0);
        chk("mid_rst_result", result_o, 32'd0);
        chk("mid_rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
        issue(2'b01, 32'd9, 32'd3, 5'd3);
        wait_done();
        step(3);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog against a stuck run
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
